// File: rtl/mac_kxk_acc.sv
// Pipelined KxK multiply-accumulate engine with cross-channel accumulation, bias,
// rounding, saturation and optional ReLU. Stages: products, adder tree, accumulate, output.
module mac_kxk_acc #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned FRAC_BITS  = 8,
   parameter int unsigned K          = 3,
   parameter int unsigned ACC_WIDTH  = 40,
   parameter bit          ROUND_EN   = 1'b1,
   parameter bit          SAT_EN     = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         in_last,
   input  logic [K*K*DATA_WIDTH-1:0]    px_flat,
   input  logic [K*K*DATA_WIDTH-1:0]    w_flat,
   input  logic [DATA_WIDTH-1:0]        bias,
   input  logic                         relu_en,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic                         out_sat
);

   localparam int unsigned N   = K * K;
   localparam int unsigned PW  = 2 * DATA_WIDTH;
   localparam int unsigned RSH = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
   localparam logic [ACC_WIDTH-1:0] RND =
      (ROUND_EN && FRAC_BITS > 0) ? (ACC_WIDTH'(1) << RSH) : '0;

   // Every stage advances together unless the output register is held.
   logic advance;
   assign advance  = !(out_valid && !out_ready);
   assign in_ready = rst_n && advance;

   logic signed [PW-1:0]         prod_c [N];
   logic signed [PW-1:0]         s1_prod [N];
   logic                         s1_valid, s1_last, s1_relu;
   logic [DATA_WIDTH-1:0]        s1_bias;

   logic signed [ACC_WIDTH-1:0]  sum_c;
   logic signed [ACC_WIDTH-1:0]  s2_sum;
   logic                         s2_valid, s2_last, s2_relu;
   logic [DATA_WIDTH-1:0]        s2_bias;

   logic signed [ACC_WIDTH-1:0]  acc, res;
   logic                         res_valid, res_relu;
   logic [ACC_WIDTH-1:0]         bias_sh_c;

   logic signed [ACC_WIDTH-1:0]  rnd_c, shr_c;
   logic [ACC_WIDTH-DATA_WIDTH:0] hi_c;
   logic                         ovf_c, sat_c;
   logic [DATA_WIDTH-1:0]        data_c;

   always_comb begin
      for (int unsigned i = 0; i < N; i++) begin
         prod_c[i] = PW'($signed(px_flat[i*DATA_WIDTH +: DATA_WIDTH]))
                   * PW'($signed(w_flat[i*DATA_WIDTH +: DATA_WIDTH]));
      end
   end

   // Adder tree over the registered products, sign-extended to the accumulator width.
   always_comb begin
      sum_c = '0;
      for (int unsigned i = 0; i < N; i++) begin
         sum_c = sum_c + {{(ACC_WIDTH-PW){s1_prod[i][PW-1]}}, s1_prod[i]};
      end
   end

   assign bias_sh_c = {{(ACC_WIDTH-DATA_WIDTH){s2_bias[DATA_WIDTH-1]}}, s2_bias} << FRAC_BITS;

   // Round, rescale, clamp and rectify the finished pixel.
   always_comb begin
      rnd_c  = res + RND;
      shr_c  = rnd_c >>> FRAC_BITS;
      hi_c   = shr_c[ACC_WIDTH-1:DATA_WIDTH-1];
      ovf_c  = !((&hi_c) || !(|hi_c));
      sat_c  = 1'b0;
      data_c = shr_c[DATA_WIDTH-1:0];
      if (SAT_EN && ovf_c) begin
         sat_c  = 1'b1;
         data_c = shr_c[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                     : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end
      if (res_relu && data_c[DATA_WIDTH-1]) begin
         data_c = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < N; i++) begin
            s1_prod[i] <= '0;
         end
         s1_valid  <= 1'b0;
         s1_last   <= 1'b0;
         s1_relu   <= 1'b0;
         s1_bias   <= '0;
         s2_sum    <= '0;
         s2_valid  <= 1'b0;
         s2_last   <= 1'b0;
         s2_relu   <= 1'b0;
         s2_bias   <= '0;
         acc       <= '0;
         res       <= '0;
         res_valid <= 1'b0;
         res_relu  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
      end else if (advance) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_prod <= prod_c;
            s1_last <= in_last;
            if (in_last) begin
               s1_bias <= bias;
               s1_relu <= relu_en;
            end
         end

         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_sum  <= sum_c;
            s2_last <= s1_last;
            s2_bias <= s1_bias;
            s2_relu <= s1_relu;
         end

         res_valid <= s2_valid && s2_last;
         if (s2_valid) begin
            if (s2_last) begin
               res      <= acc + s2_sum + bias_sh_c;
               res_relu <= s2_relu;
               acc      <= '0;
            end else begin
               acc <= acc + s2_sum;
            end
         end

         out_valid <= res_valid;
         if (res_valid) begin
            out_data <= data_c;
            out_sat  <= sat_c;
         end
      end
   end

endmodule

// File: tb/tb_mac_kxk_acc.sv
// Directed + randomized bench for mac_kxk_acc; a rounding and a truncating instance run in lockstep
// against a scoreboard of expected results.
module tb_mac_kxk_acc;

   localparam int unsigned DW = 16;
   localparam int unsigned N  = 9;
   localparam int unsigned NW = N * DW;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, in_valid, in_last, relu_en, out_ready;
   logic [NW-1:0] px_flat, w_flat;
   logic [DW-1:0] bias;
   logic          in_ready0, in_ready1, out_valid0, out_valid1, out_sat0, out_sat1;
   logic [DW-1:0] out_data0, out_data1;

   mac_kxk_acc #(.ROUND_EN(1'b1)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .in_last(in_last),
      .px_flat(px_flat), .w_flat(w_flat), .bias(bias), .relu_en(relu_en),
      .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_sat(out_sat0));

   mac_kxk_acc #(.ROUND_EN(1'b0)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .in_last(in_last),
      .px_flat(px_flat), .w_flat(w_flat), .bias(bias), .relu_en(relu_en),
      .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_sat(out_sat1));

   typedef struct {
      logic [DW-1:0] d0;
      logic          s0;
      logic [DW-1:0] d1;
      logic          s1;
   } exp_t;

   exp_t          sbq[$];
   int            total = 0;
   int            bad   = 0;
   bit            accepted, held, rand_ready;
   logic [DW-1:0] hd0;
   logic          hs0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [DW-1:0] d0, input logic s0, input logic [DW-1:0] d1, input logic s1);
      exp_t e;
      e.d0 = d0; e.s0 = s0; e.d1 = d1; e.s1 = s1;
      sbq.push_back(e);
   endtask

   // Pre-edge observation: handshake rules, hold stability, scoreboard pops.
   task automatic sample();
      exp_t e;
      chk("in_ready", 32'(in_ready0), 32'(rst_n && !(out_valid0 && !out_ready)));
      chk("in_ready_lockstep", 32'(in_ready1), 32'(in_ready0));
      chk("valid_lockstep", 32'(out_valid1), 32'(out_valid0));
      if (held) begin
         chk("hold_valid", 32'(out_valid0), 32'd1);
         chk("hold_data", 32'(out_data0), 32'(hd0));
         chk("hold_sat", 32'(out_sat0), 32'(hs0));
      end
      if (out_valid0 && sbq.size() == 0) begin
         chk("spurious_valid", 32'(out_valid0), 32'd0);
      end else if (out_valid0 && out_ready) begin
         e = sbq.pop_front();
         chk("data_rnd", 32'(out_data0), 32'(e.d0));
         chk("sat_rnd", 32'(out_sat0), 32'(e.s0));
         chk("data_trunc", 32'(out_data1), 32'(e.d1));
         chk("sat_trunc", 32'(out_sat1), 32'(e.s1));
      end
      held     = rst_n && out_valid0 && !out_ready;
      hd0      = out_data0;
      hs0      = out_sat0;
      accepted = in_valid && in_ready0;
   endtask

   task automatic tick();
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic send(input logic [NW-1:0] p, input logic [NW-1:0] w, input logic last,
                       input logic [DW-1:0] b, input logic r);
      px_flat  = p;
      w_flat   = w;
      in_last  = last;
      bias     = b;
      relu_en  = r;
      in_valid = 1'b1;
      accepted = 1'b0;
      for (int i = 0; i < 40 && !accepted; i++) tick();
      chk("accept_timeout", 32'(accepted), 32'd1);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && sbq.size() > 0; i++) tick();
      chk("drain", 32'(sbq.size()), 32'd0);
      for (int i = 0; i < 4; i++) tick();
   endtask

   function automatic logic [NW-1:0] fill(input logic [DW-1:0] v);
      logic [NW-1:0] f;
      for (int i = 0; i < int'(N); i++) f[i*DW +: DW] = v;
      return f;
   endfunction

   function automatic logic [NW-1:0] first(input logic [DW-1:0] v);
      logic [NW-1:0] f;
      f = '0;
      f[DW-1:0] = v;
      return f;
   endfunction

   function automatic logic [NW-1:0] rnd_vec();
      logic [NW-1:0] f;
      for (int i = 0; i < int'(N); i++) f[i*DW +: DW] = 16'($urandom);
      return f;
   endfunction

   function automatic longint dot(input logic [NW-1:0] p, input logic [NW-1:0] w);
      logic [DW-1:0] a, b;
      longint s;
      s = 0;
      for (int i = 0; i < int'(N); i++) begin
         a = p[i*DW +: DW];
         b = w[i*DW +: DW];
         s += longint'($signed(a)) * longint'($signed(b));
      end
      return s;
   endfunction

   // Q8.8 output model: bias align, optional half-up round, shift, clamp, ReLU.
   task automatic model(input longint acc, input logic [DW-1:0] b, input logic r, input bit rnd,
                        output logic [DW-1:0] d, output logic s);
      longint v;
      v = acc + (longint'($signed(b)) <<< 8);
      if (rnd) v += 128;
      v = v >>> 8;
      s = 1'b0;
      if (v > 32767) begin
         v = 32767; s = 1'b1;
      end else if (v < -32768) begin
         v = -32768; s = 1'b1;
      end
      if (r && v < 0) v = 0;
      d = v[DW-1:0];
   endtask

   initial begin
      longint        acc;
      logic [NW-1:0] p, w;
      logic [DW-1:0] b, d0, d1;
      logic          r, s0, s1;
      int            ch;

      rand_ready = 1'b0;
      held       = 1'b0;
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_last    = 1'b0;
      px_flat    = '0;
      w_flat     = '0;
      bias       = '0;
      relu_en    = 1'b0;
      out_ready  = 1'b1;
      tick();
      tick();
      chk("rst_out_valid", 32'(out_valid0), 32'd0);
      chk("rst_out_data", 32'(out_data0), 32'd0);
      chk("rst_out_sat", 32'(out_sat0), 32'd0);
      chk("rst_in_ready", 32'(in_ready0), 32'd0);
      rst_n = 1'b1;
      tick();

      // single channel, unity, with latency probe
      send(fill(16'h0100), fill(16'h0100), 1'b1, 16'h0000, 1'b0);
      push(16'h0900, 1'b0, 16'h0900, 1'b0);
      chk("lat_n0", 32'(out_valid0), 32'd0);
      tick();
      chk("lat_n1", 32'(out_valid0), 32'd0);
      tick();
      chk("lat_n2", 32'(out_valid0), 32'd0);
      tick();
      chk("lat_n3_valid", 32'(out_valid0), 32'd1);
      chk("lat_n3_data", 32'(out_data0), 32'h0900);
      drain();

      // four channels plus bias
      for (int c = 0; c < 4; c++) send(fill(16'h0100), fill(16'h0080), c == 3, 16'h0100, 1'b0);
      push(16'h1300, 1'b0, 16'h1300, 1'b0);
      drain();

      // saturation and ReLU, back to back
      send(fill(16'h7FFF), fill(16'h7FFF), 1'b1, 16'h0000, 1'b0);
      push(16'h7FFF, 1'b1, 16'h7FFF, 1'b1);
      send(fill(16'h7FFF), fill(16'h8001), 1'b1, 16'h0000, 1'b0);
      push(16'h8000, 1'b1, 16'h8000, 1'b1);
      send(fill(16'h7FFF), fill(16'h8001), 1'b1, 16'h0000, 1'b1);
      push(16'h0000, 1'b1, 16'h0000, 1'b1);
      drain();

      // rounding versus truncation
      send(first(16'h0001), first(16'h0080), 1'b1, 16'h0000, 1'b0);
      push(16'h0001, 1'b0, 16'h0000, 1'b0);
      send(first(16'hFFFF), first(16'h0080), 1'b1, 16'h0000, 1'b0);
      push(16'h0000, 1'b0, 16'hFFFF, 1'b0);
      drain();

      // backpressure: two results held behind a stalled output
      out_ready = 1'b0;
      send(fill(16'h0100), fill(16'h0100), 1'b1, 16'h0000, 1'b0);
      push(16'h0900, 1'b0, 16'h0900, 1'b0);
      send(fill(16'h0200), fill(16'h0100), 1'b1, 16'h0000, 1'b0);
      push(16'h1200, 1'b0, 16'h1200, 1'b0);
      for (int i = 0; i < 5; i++) tick();
      chk("stall_in_ready", 32'(in_ready0), 32'd0);
      chk("stall_valid", 32'(out_valid0), 32'd1);
      chk("stall_data", 32'(out_data0), 32'h0900);
      out_ready = 1'b1;
      drain();

      // reset discards a partial accumulation
      send(fill(16'h0100), fill(16'h0100), 1'b0, 16'h0000, 1'b0);
      send(fill(16'h0100), fill(16'h0100), 1'b0, 16'h0000, 1'b0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      send(fill(16'h0100), fill(16'h0100), 1'b1, 16'h0000, 1'b0);
      push(16'h0900, 1'b0, 16'h0900, 1'b0);
      drain();

      // randomized multi-channel runs with random downstream readiness
      rand_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         ch  = int'($urandom_range(1, 3));
         acc = 0;
         b   = 16'($urandom);
         r   = 1'($urandom_range(0, 1));
         for (int c = 0; c < ch; c++) begin
            p = rnd_vec();
            w = rnd_vec();
            acc += dot(p, w);
            send(p, w, c == ch - 1, b, r);
         end
         model(acc, b, r, 1'b1, d0, s0);
         model(acc, b, r, 1'b0, d1, s1);
         push(d0, s0, d1, s1);
      end
      rand_ready = 1'b0;
      out_ready  = 1'b1;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
